// File: rtl/down_count_pkg.sv
// Shared types and defaults for the ripple down-counter monitor.
package down_count_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Monitor FSM: follow the settled count, or wait for a new value to settle.
  typedef enum logic {
    TRACK,
    SETTLE
  } state_e;

  // Classification of an accepted value against the previous accepted value.
  typedef enum logic [1:0] {
    STEP_NORMAL,
    STEP_WRAP,
    STEP_SKIP
  } step_kind_e;

endpackage

// File: rtl/down_count_monitor_if.sv
// Valid/ready handshake carrying each accepted counter step downstream.
interface down_count_monitor_if
  import down_count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_count;
  logic             out_wrap;

  modport master (output out_valid, output out_count, output out_wrap, input out_ready);
  modport slave  (input out_valid, input out_count, input out_wrap, output out_ready);

endinterface

// File: rtl/down_count_monitor_bit_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
module bit_sync
  import down_count_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      // NOTE: non-blocking assignment makes each stage take the previous stage's old value, forming a real chain.
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/down_count_monitor.sv
// Consumer stage for the 4-bit ripple down counter: synchronizes the raw bits,
// qualifies each new value as stable, classifies it as step/wrap/skip and
// offers it downstream over a valid/ready handshake.
module down_count_monitor
  import down_count_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic                  clr,
  down_count_monitor_if.master  out_if,
  output logic [WRAP_W-1:0]     wrap_count,
  output logic                  step_err,
  output logic                  overrun
);

  localparam int                STAB_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [WIDTH-1:0]  ALL_ONES = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic [WIDTH-1:0] s;

  // Upstream counter resets to all-ones, so the synchronizers do too.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    bit_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (cnt_in[i]),
      .q_o   (s[i])
    );
  end

  state_e           state_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] last_q;
  logic [STAB_W-1:0] stab_q;
  logic             accept;
  step_kind_e       kind;

  // A candidate is accepted on the edge after its STABLE_CYCLES-th matching
  // sample, provided it is still present on that edge.
  assign accept = (state_q == SETTLE) && (s == cand_q) && (stab_q == STAB_MAX);

  // Classify the candidate against the last accepted value.
  always_comb begin
    kind = STEP_SKIP;
    if ((last_q != '0) && (cand_q == last_q - WIDTH'(1))) begin
      kind = STEP_NORMAL;
    end else if ((last_q == '0) && (cand_q == ALL_ONES)) begin
      kind = STEP_WRAP;
    end
  end

  // Settling FSM: track the settled value, qualify changes, drop glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TRACK;
      cand_q  <= ALL_ONES;
      last_q  <= ALL_ONES;
      stab_q  <= '0;
    end else begin
      case (state_q)
        TRACK: begin
          if (s != last_q) begin
            cand_q  <= s;
            stab_q  <= STAB_W'(1);
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (s == cand_q) begin
            if (stab_q == STAB_MAX) begin
              // Later steps are judged against the true count, even after a skip.
              last_q  <= cand_q;
              state_q <= TRACK;
            end else begin
              stab_q <= stab_q + STAB_W'(1);
            end
          end else if (s == last_q) begin
            state_q <= TRACK;
          end else begin
            cand_q <= s;
            stab_q <= STAB_W'(1);
          end
        end
        default: state_q <= TRACK;
      endcase
    end
  end

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              step_err_q, step_err_d;
  logic              overrun_q, overrun_d;
  logic              stalled;

  assign stalled = valid_q && !out_if.out_ready;

  // Next state of the output register and the sticky status flags.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    valid_d    = valid_q;
    count_d    = count_q;
    wrap_d     = wrap_q;
    wrap_cnt_d = wrap_cnt_q;
    step_err_d = step_err_q;
    overrun_d  = overrun_q;
    if (accept) begin
      if (stalled) begin
        overrun_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        count_d = cand_q;
        wrap_d  = (kind == STEP_WRAP);
      end
      if ((kind == STEP_WRAP) && (wrap_cnt_q != WRAP_MAX)) begin
        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
      if (kind == STEP_SKIP) begin
        step_err_d = 1'b1;
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
    // Clear wins over a same-edge increment or flag; the event itself survives.
    if (clr) begin
      wrap_cnt_d = '0;
      step_err_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  // Register the handshake outputs and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      count_q    <= ALL_ONES;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      step_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      step_err_q <= step_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_count = count_q;
  assign out_if.out_wrap  = wrap_q;
  assign wrap_count       = wrap_cnt_q;
  assign step_err         = step_err_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor with hand-computed expectations.
module tb_down_count_monitor;
  import down_count_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] cnt_in;
  logic [7:0] wrap_count;
  logic       step_err;
  logic       overrun;

  int vectors     = 0;
  int miscompares = 0;

  down_count_monitor_if #(.WIDTH(4)) bus ();

  down_count_monitor #(
    .WIDTH         (4),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (2),
    .WRAP_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .out_if     (bus),
    .wrap_count (wrap_count),
    .step_err   (step_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply a value at a negedge and hold it 10 cycles; sample after edges 4 and 5.
  task automatic drive_step(input logic [3:0] val, output logic early_v, output logic v,
                            output logic [3:0] c, output logic w);
    cnt_in = val;
    tick(4);
    early_v = bus.out_valid;
    tick(1);
    v = bus.out_valid;
    c = bus.out_count;
    w = bus.out_wrap;
    tick(5);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b0; clr = 1'b0; cnt_in = 4'hF; bus.out_ready = 1'b1;
    tick(3);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_count !== 4'hF) begin miscompares++; $display("FAIL rst_count: got %h want f", bus.out_count); end
    vectors++; if (bus.out_wrap !== 1'b0) begin miscompares++; $display("FAIL rst_wrap: got %b want 0", bus.out_wrap); end
    vectors++; if ({wrap_count, step_err, overrun} !== 10'd0) begin miscompares++; $display("FAIL rst_flags: got %h/%b/%b want 0/0/0", wrap_count, step_err, overrun); end
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(1); seen |= bus.out_valid; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b want 0", seen); end
    vectors++; if ({wrap_count, step_err, overrun} !== 10'd0) begin miscompares++; $display("FAIL idle_flags: got %h/%b/%b want 0/0/0", wrap_count, step_err, overrun); end
  endtask

  task automatic test_basic();
    logic e, v, w; logic [3:0] c;
    drive_step(4'hE, e, v, c, w);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL e_early: got %b want 0", e); end
    vectors++; if ({v, c, w} !== {1'b1, 4'hE, 1'b0}) begin miscompares++; $display("FAIL e_event: got v%b c%h w%b want v1 ce w0", v, c, w); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL e_drop: got %b want 0", bus.out_valid); end
    drive_step(4'hD, e, v, c, w);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL d_early: got %b want 0", e); end
    vectors++; if ({v, c, w} !== {1'b1, 4'hD, 1'b0}) begin miscompares++; $display("FAIL d_event: got v%b c%h w%b want v1 cd w0", v, c, w); end
  endtask

  task automatic test_wrap();
    logic e, v, w; logic [3:0] c;
    drive_step(4'h3, e, v, c, w);
    vectors++; if ({v, c, step_err} !== {1'b1, 4'h3, 1'b1}) begin miscompares++; $display("FAIL d3_skip: got v%b c%h err%b want v1 c3 err1", v, c, step_err); end
    pulse_clr();
    vectors++; if ({wrap_count, step_err} !== 9'd0) begin miscompares++; $display("FAIL clr1: got %h/%b want 0/0", wrap_count, step_err); end
    for (int k = 2; k >= 0; k--) begin
      drive_step(4'(k), e, v, c, w);
      vectors++; if ({v, c, w} !== {1'b1, 4'(k), 1'b0}) begin miscompares++; $display("FAIL walk_%0d: got v%b c%h w%b want v1 c%h w0", k, v, c, w, 4'(k)); end
    end
    drive_step(4'hF, e, v, c, w);
    vectors++; if ({v, c, w} !== {1'b1, 4'hF, 1'b1}) begin miscompares++; $display("FAIL wrap_event: got v%b c%h w%b want v1 cf w1", v, c, w); end
    vectors++; if ({wrap_count, step_err} !== {8'd1, 1'b0}) begin miscompares++; $display("FAIL wrap_count: got %0d/%b want 1/0", wrap_count, step_err); end
  endtask

  task automatic test_skip();
    logic e, v, w; logic [3:0] c;
    drive_step(4'hE, e, v, c, w);
    vectors++; if ({v, c, step_err} !== {1'b1, 4'hE, 1'b0}) begin miscompares++; $display("FAIL fe_step: got v%b c%h err%b want v1 ce err0", v, c, step_err); end
    drive_step(4'hA, e, v, c, w);
    vectors++; if ({v, c, w, step_err} !== {1'b1, 4'hA, 1'b0, 1'b1}) begin miscompares++; $display("FAIL ea_skip: got v%b c%h w%b err%b want v1 ca w0 err1", v, c, w, step_err); end
    drive_step(4'h9, e, v, c, w);
    vectors++; if ({v, c, w, step_err} !== {1'b1, 4'h9, 1'b0, 1'b1}) begin miscompares++; $display("FAIL a9_sticky: got v%b c%h w%b err%b want v1 c9 w0 err1", v, c, w, step_err); end
    vectors++; if (wrap_count !== 8'd1) begin miscompares++; $display("FAIL skip_wraps: got %0d want 1", wrap_count); end
    pulse_clr();
    vectors++; if ({wrap_count, step_err} !== 9'd0) begin miscompares++; $display("FAIL clr2: got %h/%b want 0/0", wrap_count, step_err); end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    cnt_in = 4'h7; tick(1); cnt_in = 4'h9;
    for (int i = 0; i < 10; i++) begin tick(1); seen |= bus.out_valid; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL glitch1: got %b want 0", seen); end
    cnt_in = 4'h8; tick(2); cnt_in = 4'h9;
    for (int i = 0; i < 10; i++) begin tick(1); seen |= bus.out_valid; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL glitch2: got %b want 0", seen); end
    cnt_in = 4'h8; tick(3); cnt_in = 4'h7; tick(2);
    vectors++; if ({bus.out_valid, bus.out_count} !== {1'b1, 4'h8}) begin miscompares++; $display("FAIL hold3: got v%b c%h want v1 c8", bus.out_valid, bus.out_count); end
    tick(1);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL hold3_drop: got %b want 0", bus.out_valid); end
    tick(2);
    vectors++; if ({bus.out_valid, bus.out_count, step_err} !== {1'b1, 4'h7, 1'b0}) begin miscompares++; $display("FAIL next7: got v%b c%h err%b want v1 c7 err0", bus.out_valid, bus.out_count, step_err); end
    tick(5);
  endtask

  task automatic test_back_to_back();
    logic e, v, w, seen; logic [3:0] c;
    bus.out_ready = 1'b0;
    drive_step(4'h6, e, v, c, w);
    vectors++; if ({e, v, c, overrun} !== {1'b0, 1'b1, 4'h6, 1'b0}) begin miscompares++; $display("FAIL bp6: got e%b v%b c%h ovr%b want e0 v1 c6 ovr0", e, v, c, overrun); end
    drive_step(4'h5, e, v, c, w);
    vectors++; if ({v, c, overrun} !== {1'b1, 4'h6, 1'b1}) begin miscompares++; $display("FAIL bp_hold: got v%b c%h ovr%b want v1 c6 ovr1", v, c, overrun); end
    bus.out_ready = 1'b1; tick(1);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
    drive_step(4'h4, e, v, c, w);
    vectors++; if ({e, v, c, w, step_err, overrun} !== {1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL bp_next: got e%b v%b c%h w%b err%b ovr%b want e0 v1 c4 w0 err0 ovr1", e, v, c, w, step_err, overrun); end
    cnt_in = 4'h3; tick(3);
    rst = 1'b0; #1;
    vectors++; if ({bus.out_valid, bus.out_count, bus.out_wrap} !== {1'b0, 4'hF, 1'b0}) begin miscompares++; $display("FAIL mid_rst_out: got v%b c%h w%b want v0 cf w0", bus.out_valid, bus.out_count, bus.out_wrap); end
    vectors++; if ({wrap_count, step_err, overrun} !== 10'd0) begin miscompares++; $display("FAIL mid_rst_flags: got %h/%b/%b want 0/0/0", wrap_count, step_err, overrun); end
    cnt_in = 4'hF; tick(3); rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(1); seen |= bus.out_valid; end
    vectors++; if ({seen, bus.out_count} !== {1'b0, 4'hF}) begin miscompares++; $display("FAIL post_rst: got v%b c%h want v0 cf", seen, bus.out_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_skip();
    test_glitch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
